fir_tap_sequencer: RTL
======================

# fir_tap_sequencer

Upstream control and data stage for the FIR MAC. On each input-sample strobe it shifts the new sample into a TAPS-deep delay line. It then walks every tap in turn: it reads the tap's coefficient from the single-port coefficient SRAM and presents each delay/coefficient pair to the MAC, together with the MAC's iEnMul and iEnAddAcc enables, in the correct pipelined order. It signals completion so the output stage can capture the MAC result.

## Interface
- TAPS, 10: number of filter taps (delay-line depth and coefficient count)
- DATA_W, 30: delay-line sample width (matches MAC iDelay)
- COEF_W, 16: coefficient width (matches MAC iCoeff)
- ADDR_W, 4: coefficient SRAM address width; must satisfy 2**ADDR_W >= TAPS

Ports:
- iClk12M  in  1  system clock; single clock domain
- iRsn  in  1  asynchronous, active-low reset
- iEnSample  in  1  one-cycle strobe: iFirIn holds a new sample
- iFirIn  in  DATA_W  signed input sample
- iCoeffRdata  in  COEF_W  SRAM read data, valid one cycle after a read is issued
- oCsn  out  1  SRAM chip select, active-low; low only while issuing a read
- oAddr  out  ADDR_W  SRAM read address
- oDelay  out  DATA_W  delay-tap value to MAC iDelay
- oCoeff  out  COEF_W  coefficient to MAC iCoeff
- oEnMul  out  1  to MAC iEnMul
- oEnAddAcc  out  1  to MAC iEnAddAcc
- oAccClr  out  1  one-cycle accumulator-clear request to the MAC/output stage
- oBusy  out  1  high from the first RUN cycle through the last oEnAddAcc cycle
- oDone  out  1  one-cycle pulse when the MAC holds the final sum
- oOverrun  out  1  one-cycle pulse when iEnSample arrives while busy

## Operation
- Delay line: tap[0..TAPS-1], each DATA_W wide. On an accepted sample: tap[0] <= iFirIn and tap[i] <= tap[i-1]; tap[TAPS-1] is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: iEnSample=1 -> accept the sample, shift, clear idx to 0, go to RUN.
  - RUN: oCsn=0, oAddr=idx, idx++. After issuing idx=TAPS-1, go to DRAIN.
  - DRAIN: stays for 2 cycles so the mul and add stages can empty, then goes to DONE.
  - DONE: oDone=1 for one cycle, then returns to IDLE.
- Pipeline, per tap k:
  - stage 0 (RUN): read issued at address k.
  - stage 1: oCoeff=iCoeffRdata, oDelay=tap[k], oEnMul=1.
  - stage 2: oEnAddAcc=1.
  - The stage-1 and stage-2 valid bits and the stage-1 index are registered.
- oDelay and oCoeff are held at their last values when oEnMul=0.
- oAccClr pulses in the first RUN cycle, two cycles ahead of the first oEnAddAcc.
- iEnSample in any state other than IDLE: the sample is dropped, the delay line is unchanged, and oOverrun pulses in the following cycle.
- iEnSample in the same cycle as DONE: also dropped with oOverrun. A sample is accepted only in IDLE.
- Arithmetic: none. This block only moves data; it adds no sign extension and no truncation.

## Timing
- Cycle 0 is the edge that samples iEnSample=1 in IDLE.
  - Cycles 1..TAPS: RUN.
  - Cycles 2..TAPS+1: oEnMul.
  - Cycles 3..TAPS+2: oEnAddAcc.
  - Cycle TAPS+3: oDone.
- Sample-to-done latency is TAPS+3 cycles. Maximum sample rate is one sample per TAPS+4 cycles.
- oBusy is high during cycles 1..TAPS+2.
- Reset (asynchronous, any time, including mid-sequence): state=IDLE, idx=0, all taps=0, and pipeline valids=0. Outputs: oCsn=1, oAddr=0, oDelay=0, oCoeff=0, and all enables and pulses 0. There is no partial completion and no oDone.
- Release from reset: the first iEnSample is accepted on the first edge with iRsn=1.

## Structure
- Shared package fir_pkg holds:
  - the DATA_W, COEF_W, ADDR_W and TAPS defaults;
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the derived constant LAST_IDX = TAPS-1.
- Natural sub-module: fir_delay_line, parameterised by TAPS and DATA_W, with a shift enable and an index-read port. The FSM and pipeline registers stay in fir_tap_sequencer.

## Test plan
- Reset, then SRAM model preloaded with coeff[k]=k+1 and iFirIn=100 strobed once.
  - Required: the reads hit addresses 0..9 in cycles 1..10.
  - oEnMul pairs are (100,1) followed by (0,2..10).
  - oDone pulses at cycle 13.
- Impulse response: samples 1,0,0,... issued every 14 cycles.
  - Required: on the n-th run, tap[n] carries 1 while all other taps carry 0.
- Back-to-back strobes: iEnSample asserted at cycles 0 and 5.
  - Required: the second strobe is dropped, oOverrun pulses at cycle 6, and the delay line holds only the first sample.
- Strobe in the same cycle as oDone.
  - Required: the strobe is dropped with oOverrun, and a strobe one cycle later is accepted.
- Asynchronous reset asserted at cycle 6 of a run.
  - Required: all outputs are 0 immediately, oCsn=1, no oDone, and a new run after release matches the first scenario.
- TAPS=4 build.
  - Required: oDone at cycle 7, and oAddr never exceeds 3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR tap sequencer.
// Pure declarations: no latency, no flow control.
package fir_pkg;

    localparam int FIR_TAPS   = 10;
    localparam int FIR_DATA_W = 30;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_ADDR_W = 4;
    localparam int LAST_IDX   = FIR_TAPS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int last_idx(input int taps);
        return taps - 1;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register with one combinational index-read port.
// Shift takes effect on the enabling edge; read is same-cycle; no backpressure.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int TAPS   = FIR_TAPS,
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = FIR_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_shift_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [TAPS-1:0][DATA_W-1:0] r_tap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap <= '0;
        end else if (i_shift_en) begin
            r_tap <= {r_tap[TAPS-2:0], i_din};
        end
    end

    // Compare-and-select keeps out-of-range indices at zero instead of X.
    always_comb begin
        o_rd_dat = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (i_rd_idx == ADDR_W'(i)) begin
                o_rd_dat = r_tap[i];
            end
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Shifts each sample into the delay line, then streams tap/coefficient pairs and enables to the MAC.
// Sample-to-oDone latency TAPS+3; no backpressure, strobes outside IDLE are dropped with oOverrun.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS   = FIR_TAPS,
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ADDR_W = FIR_ADDR_W
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample,
    input  logic [DATA_W-1:0] iFirIn,
    input  logic [COEF_W-1:0] iCoeffRdata,
    output logic              oCsn,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oDelay,
    output logic [COEF_W-1:0] oCoeff,
    output logic              oEnMul,
    output logic              oEnAddAcc,
    output logic              oAccClr,
    output logic              oBusy,
    output logic              oDone,
    output logic              oOverrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_idx(TAPS));

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_drain_cnt;
    logic              w_drain_nxt;
    logic              w_accept;
    logic              w_issue;

    logic              r_s1_vld;
    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s1_idx;
    logic [DATA_W-1:0] r_delay_hold;
    logic [COEF_W-1:0] r_coeff_hold;
    logic              r_overrun;
    logic [DATA_W-1:0] w_tap_rd;

    fir_delay_line #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_delay_line (
        .i_clk      (iClk12M),
        .i_rst_n    (iRsn),
        .i_shift_en (w_accept),
        .i_din      (iFirIn),
        .i_rd_idx   (r_s1_idx),
        .o_rd_dat   (w_tap_rd)
    );

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_drain_nxt = r_drain_cnt;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        oBusy       = 1'b0;
        oAccClr     = 1'b0;
        oDone       = 1'b0;
        case (r_state)
            IDLE: begin
                if (iEnSample) begin
                    w_accept    = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                oBusy   = 1'b1;
                // idx is zero in RUN only on the first read of a sequence.
                oAccClr = (r_idx == '0);
                if (r_idx == LAST_ADDR) begin
                    w_idx_nxt   = '0;
                    w_drain_nxt = 1'b0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            DRAIN: begin
                oBusy       = 1'b1;
                w_drain_nxt = 1'b1;
                if (r_drain_cnt) begin
                    w_drain_nxt = 1'b0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                oDone       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign oCsn  = ~w_issue;
    assign oAddr = r_idx;

    // Stage 1 lines up with the SRAM read data; stage 2 is the accumulate slot.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_s1_vld     <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s1_idx     <= '0;
            r_delay_hold <= '0;
            r_coeff_hold <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_s1_vld  <= w_issue;
            r_s1_idx  <= r_idx;
            r_s2_vld  <= r_s1_vld;
            r_overrun <= iEnSample && (r_state != IDLE);
            if (r_s1_vld) begin
                r_delay_hold <= w_tap_rd;
                r_coeff_hold <= iCoeffRdata;
            end
        end
    end

    assign oEnMul    = r_s1_vld;
    assign oEnAddAcc = r_s2_vld;
    assign oDelay    = r_s1_vld ? w_tap_rd    : r_delay_hold;
    assign oCoeff    = r_s1_vld ? iCoeffRdata : r_coeff_hold;
    assign oOverrun  = r_overrun;

endmodule
